// File: rtl/adder_stage_sequencer.sv
// Sequencer around a 4-bit ripple-carry adder: launches an operand pair,
// waits a fixed number of cycles for the ripple to settle, captures the
// result and hands it downstream over valid/ready. It also keeps a
// saturating count of overflow results.
module adder_stage_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_sum,
  input  logic       add_carryout,
  input  logic       add_overflow,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic       out_carryout,
  output logic       out_overflow,
  output logic       busy,
  input  logic       clear_stats,
  output logic [7:0] ovf_count
);

  localparam int unsigned OVF_W = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [OVF_W-1:0] OVF_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             capture;
  logic             handoff;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic plus the strobes and flags decoded from the state
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    handoff   = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        busy = 1'b1;
        if (out_ready) begin
          handoff   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Settle countdown, loaded on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt <= '0;
    else if (accept)                           cnt <= CNT_LOAD;
    else if (state == S_SETTLE && cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  // Operand registers drive the adder and hold until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a <= '0;
      add_b <= '0;
    end else if (accept) begin
      add_a <= in_a;
      add_b <= in_b;
    end
  end

  // Result registers hold until the next capture, even after handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum      <= '0;
      out_carryout <= 1'b0;
      out_overflow <= 1'b0;
    end else if (capture) begin
      out_sum      <= add_sum;
      out_carryout <= add_carryout;
      out_overflow <= add_overflow;
    end
  end

  // Result valid: set at capture, cleared at downstream handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       out_valid <= 1'b0;
    else if (capture) out_valid <= 1'b1;
    else if (handoff) out_valid <= 1'b0;
  end

  // Saturating overflow counter; clear wins over a same-edge increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ovf_count <= '0;
    else if (clear_stats) ovf_count <= '0;
    else if (capture && add_overflow && ovf_count != OVF_MAX)
      ovf_count <= ovf_count + OVF_W'(1);
  end

endmodule

// File: tb/tb_adder_stage_sequencer.sv
// Bench for adder_stage_sequencer: a default build wrapped around a slow
// adder model, plus a SETTLE_CYCLES=1 build driven back to back.
module tb_adder_stage_sequencer;

  localparam int S0 = 4;

  logic       clk;
  logic       rst_n;
  int         checks   = 0;
  int         failures = 0;
  int         exp_ovf  = 0;
  int         exp_ovf1 = 0;

  // default build
  logic       in_valid, in_ready, out_valid, out_ready, busy, clear_stats;
  logic [3:0] in_a, in_b, add_a, add_b, add_sum, out_sum;
  logic       add_carryout, add_overflow, out_carryout, out_overflow;
  logic [7:0] ovf_count;

  // single-cycle settle build
  logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1, clear_stats1;
  logic [3:0] in_a1, in_b1, add_a1, add_b1, add_sum1, out_sum1;
  logic       add_carryout1, add_overflow1, out_carryout1, out_overflow1;
  logic [7:0] ovf_count1;

  adder_stage_sequencer #(.SETTLE_CYCLES(S0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .add_carryout(add_carryout), .add_overflow(add_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carryout(out_carryout), .out_overflow(out_overflow),
    .busy(busy), .clear_stats(clear_stats), .ovf_count(ovf_count)
  );

  adder_stage_sequencer #(.SETTLE_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .add_a(add_a1), .add_b(add_b1), .add_sum(add_sum1),
    .add_carryout(add_carryout1), .add_overflow(add_overflow1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_carryout(out_carryout1), .out_overflow(out_overflow1),
    .busy(busy1), .clear_stats(clear_stats1), .ovf_count(ovf_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slow adder model: outputs are inverted garbage until the operands have
  // been stable long enough, so a premature capture shows up as wrong data.
  int         age0 = 1000;
  logic [3:0] pa0 = '0, pb0 = '0;
  always @(negedge clk) begin
    if (add_a !== pa0 || add_b !== pb0) age0 <= 0;
    else if (age0 < 1000)               age0 <= age0 + 1;
    pa0 <= add_a;
    pb0 <= add_b;
  end

  logic [4:0] raw0, raw1;
  logic       ovf_raw0, ovf_raw1, settled0;
  assign raw0         = {1'b0, add_a} + {1'b0, add_b};
  assign ovf_raw0     = (add_a[3] == add_b[3]) && (raw0[3] != add_a[3]);
  assign settled0     = (age0 >= S0 - 1);
  assign add_sum      = settled0 ? raw0[3:0] : ~raw0[3:0];
  assign add_carryout = settled0 ? raw0[4]   : ~raw0[4];
  assign add_overflow = settled0 ? ovf_raw0  : ~ovf_raw0;

  assign raw1          = {1'b0, add_a1} + {1'b0, add_b1};
  assign ovf_raw1      = (add_a1[3] == add_b1[3]) && (raw1[3] != add_a1[3]);
  assign add_sum1      = raw1[3:0];
  assign add_carryout1 = raw1[4];
  assign add_overflow1 = ovf_raw1;

  // Reference: {overflow, carry, sum} from plain integer arithmetic
  function automatic logic [5:0] ref_add(input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, u, s;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    u  = ua + ub;
    s  = sa + sb;
    return {(s > 7 || s < -8), (u > 15), 4'(u % 16)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sum"},   out_sum, 0);
    chk({tag, "_out_co"},    out_carryout, 0);
    chk({tag, "_out_ovf"},   out_overflow, 0);
    chk({tag, "_ovf_count"}, ovf_count, 0);
    chk({tag, "_add_a"},     add_a, 0);
    chk({tag, "_add_b"},     add_b, 0);
    chk({tag, "_in_ready"},  in_ready, 1);
    chk({tag, "_busy"},      busy, 0);
  endtask

  // One transaction on the default build; hold = cycles of backpressure,
  // clr = pulse clear_stats on the capture edge.
  task automatic run_txn0(input logic [3:0] a, input logic [3:0] b,
                          input int hold, input bit clr);
    int lat;
    logic [5:0] r;
    r   = ref_add(a, b);
    lat = 0;
    while (!in_ready && lat < 20) begin @(negedge clk); lat++; end
    chk("idle_ready", in_ready, 1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 4'($urandom); in_b = 4'($urandom);
    chk("launch_a", add_a, a);
    chk("launch_b", add_b, b);
    chk("busy_settle", busy, 1);
    chk("ready_settle", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      clear_stats = clr && (lat == S0 - 1);
      @(negedge clk);
      lat++;
    end
    clear_stats = 1'b0;
    chk("latency", lat, S0);
    if (clr)                       exp_ovf = 0;
    else if (r[5] && exp_ovf < 255) exp_ovf++;
    chk("sum", out_sum, r[3:0]);
    chk("carry", out_carryout, r[4]);
    chk("ovf", out_overflow, r[5]);
    chk("ovf_count", ovf_count, exp_ovf);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_a = 4'($urandom); in_b = 4'($urandom);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, r[3:0]);
      chk("bp_carry", out_carryout, r[4]);
      chk("bp_ovf", out_overflow, r[5]);
      chk("bp_ready", in_ready, 0);
      chk("bp_add_a", add_a, a);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_valid", out_valid, 0);
    chk("handoff_ready", in_ready, 1);
    chk("held_sum", out_sum, r[3:0]);
    chk("held_add_b", add_b, b);
  endtask

  initial begin
    logic [3:0] a, b;
    logic [5:0] r;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; clear_stats = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b1; clear_stats1 = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single-cycle build, back to back: accept, capture, handoff, accept...
    in_a1 = 4'($urandom); in_b1 = 4'($urandom); in_valid1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = in_a1; b = in_b1;
      r = ref_add(a, b);
      chk("s1_ready", in_ready1, 1);
      @(negedge clk);
      chk("s1_settle_valid", out_valid1, 0);
      chk("s1_settle_ready", in_ready1, 0);
      in_a1 = 4'($urandom); in_b1 = 4'($urandom);
      @(negedge clk);
      if (r[5] && exp_ovf1 < 255) exp_ovf1++;
      chk("s1_valid", out_valid1, 1);
      chk("s1_sum", out_sum1, r[3:0]);
      chk("s1_carry", out_carryout1, r[4]);
      chk("s1_ovf", out_overflow1, r[5]);
      chk("s1_ovf_count", ovf_count1, exp_ovf1);
      @(negedge clk);
      chk("s1_handoff_valid", out_valid1, 0);
    end
    in_valid1 = 1'b0;

    // directed cases
    run_txn0(4'b0100, 4'b0100, 0, 1'b0);
    run_txn0(4'b1111, 4'b1111, 0, 1'b0);
    run_txn0(4'b1010, 4'b1001, 10, 1'b0);

    // random operands with random backpressure
    for (int i = 0; i < 20; i++)
      run_txn0(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'b0);

    // saturation, then clear on a capture edge
    for (int i = 0; i < 260; i++) run_txn0(4'b0101, 4'b0111, 0, 1'b0);
    chk("saturated", ovf_count, 255);
    run_txn0(4'b0101, 4'b0111, 0, 1'b1);

    // reset mid-SETTLE discards the in-flight pair
    in_a = 4'b1000; in_b = 4'b1000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_ovf = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_valid", out_valid, 0);
    end
    run_txn0(4'b1100, 4'b0100, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
